alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 160 ++++++++++++++++
 tb/tb_alu_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// alu_arb: arbitrates two requesters onto one shared combinational 4-bit ALU.
// Latency: accept edge N -> EXEC -> response registered at edge N+1, visible until taken.
// Backpressure: one operation in flight; readies stay low until the response is taken.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready, reqN_a/b/f     requester N command (N = 0, 1)
//   alu_a/b/f                        operands and opcode to the external ALU
//   alu_out/zero/overflow/carry      same-cycle result from the external ALU
//   rsp_valid/ready, rsp_id,
//   rsp_out/zero/overflow/carry      registered response and served requester id
module alu_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_f,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_f,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_f,
  input  logic [3:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_out,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic       rsp_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] f_q, f_d;
  logic       id_q, id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [3:0] rsp_out_q, rsp_out_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_ovf_q, rsp_ovf_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       gnt_id;
  logic       rdy0, rdy1;

  // Under contention the requester that did not win last time is served;
  // otherwise the single active requester wins (gnt_id = req1_valid).
  assign gnt_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    f_d          = f_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_carry_d  = rsp_carry_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;

    case (state_q)
      IDLE: begin
        rdy0 = req0_valid && !gnt_id;
        rdy1 = req1_valid &&  gnt_id;
        if (rdy0 || rdy1) begin
          a_d          = gnt_id ? req1_a : req0_a;
          b_d          = gnt_id ? req1_b : req0_b;
          f_d          = gnt_id ? req1_f : req0_f;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // Operands have been on alu_a/b/f for a full cycle; sample the result.
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_out_d   = alu_out;
        rsp_zero_d  = alu_zero;
        rsp_ovf_d   = alu_overflow;
        rsp_carry_d = alu_carry;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      f_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      f_q          <= f_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  // Readies are combinational from the valids; gating with rst_n keeps them
  // low for the whole reset window even while requesters hold valid high.
  assign req0_ready   = rst_n && rdy0;
  assign req1_ready   = rst_n && rdy1;

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_f        = f_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_out      = rsp_out_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_carry    = rsp_carry_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: randomized and directed bench for alu_arb with a stand-in ALU.
// Latency: transaction-level model predicts readies and response timing per cycle.
// Backpressure: rsp_ready driven fixed, held low, or randomized per phase.
module tb_alu_arb;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
  } cmd_t;

  typedef struct packed {
    logic       id;
    logic [3:0] out;
    logic       z;
    logic       o;
    logic       c;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_f, req1_f;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_f;
  logic       alu_zero, alu_overflow, alu_carry;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_carry;
  logic [3:0] rsp_out;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry)
  );

  // Reference behaviour of the shared ALU (id field left 0).
  function automatic rsp_t alu_ref(cmd_t cmd);
    rsp_t       r;
    logic [4:0] s;
    r = '0;
    s = '0;
    case (cmd.f)
      3'b000: begin
        s = {1'b0, cmd.a} + {1'b0, cmd.b};
        r.out = s[3:0]; r.c = s[4];
        r.o = (cmd.a[3] == cmd.b[3]) && (s[3] != cmd.a[3]);
      end
      3'b001: begin
        s = {1'b0, cmd.a} - {1'b0, cmd.b};
        r.out = s[3:0]; r.c = s[4];
        r.o = (cmd.a[3] != cmd.b[3]) && (s[3] != cmd.a[3]);
      end
      3'b010: r.out = cmd.a | cmd.b;
      3'b011: r.out = cmd.a & cmd.b;
      3'b100: r.out = cmd.a ^ cmd.b;
      3'b101: r.out = ~(cmd.a | cmd.b);
      3'b110: begin r.out = {cmd.a[2:0], 1'b0}; r.c = cmd.a[3]; end
      default: r.out = (cmd.a == cmd.b) ? 4'h1 : 4'h0;
    endcase
    r.z = (r.out == 4'h0);
    return r;
  endfunction

  rsp_t alu_r;
  always_comb alu_r = alu_ref(cmd_t'({alu_a, alu_b, alu_f}));
  assign alu_out      = alu_r.out;
  assign alu_zero     = alu_r.z;
  assign alu_overflow = alu_r.o;
  assign alu_carry    = alu_r.c;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   m_busy = 1'b0;
  bit   m_last = 1'b1;
  cmd_t m_cmd = '0;
  rsp_t m_exp = '0;
  cmd_t q0[$];
  cmd_t q1[$];
  rsp_t log_q[$];
  bit   rdy_rand = 1'b0;
  bit   rdy_fix = 1'b1;
  bit   rand_stim = 1'b0;
  int   n_rand_left = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    if (rand_stim && n_rand_left > 0 && q0.size() == 0 && $urandom_range(0, 2) == 0) begin
      q0.push_back(cmd_t'($urandom));
      n_rand_left--;
    end
    if (rand_stim && n_rand_left > 0 && q1.size() == 0 && $urandom_range(0, 2) == 0) begin
      q1.push_back(cmd_t'($urandom));
      n_rand_left--;
    end
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (q0.size() > 0) {req0_a, req0_b, req0_f} = q0[0];
    else {req0_a, req0_b, req0_f} = 11'($urandom);
    if (q1.size() > 0) {req1_a, req1_b, req1_f} = q1[0];
    else {req1_a, req1_b, req1_f} = 11'($urandom);
    rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
  endtask

  // One clock: check at negedge, advance the model at posedge, redrive at +1.
  task automatic step();
    bit e0, e1, exp_v, rhs;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
        e0 = (m_last == 1'b1);
        e1 = (m_last == 1'b0);
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    check_eq("one_ready", req0_ready & req1_ready, 0);
    exp_v = m_busy && (cyc > acc_cyc);
    check_eq("rsp_valid", rsp_valid, exp_v);
    if (exp_v)
      check_eq("rsp_fields", {rsp_id, rsp_out, rsp_zero, rsp_overflow, rsp_carry}, m_exp);
    check_eq("alu_operands", {alu_a, alu_b, alu_f}, m_cmd);
    rhs = exp_v && rsp_ready;
    @(posedge clk);
    cyc++;
    if (rhs) begin
      log_q.push_back(m_exp);
      m_busy = 1'b0;
    end
    if (e0 && req0_valid) begin
      m_cmd = q0.pop_front();
      m_exp = alu_ref(m_cmd);
      m_exp.id = 1'b0;
      m_last = 1'b0; m_busy = 1'b1; acc_cyc = cyc;
    end else if (e1 && req1_valid) begin
      m_cmd = q1.pop_front();
      m_exp = alu_ref(m_cmd);
      m_exp.id = 1'b1;
      m_last = 1'b1; m_busy = 1'b1; acc_cyc = cyc;
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("reset_outputs",
             {req0_ready, req1_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_id,
              rsp_out, rsp_zero, rsp_overflow, rsp_carry}, 0);
    m_busy = 1'b0;
    m_last = 1'b1;
    m_cmd  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy ||
            (rand_stim && n_rand_left > 0)) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive();
    do_reset();
    repeat (2) step();

    // Single requester add: 7 + 1 sets overflow only.
    q0.push_back(cmd_t'({4'h7, 4'h1, 3'b000}));
    drive();
    wait_idle("add", 20);
    check_eq("add_count", log_q.size(), 1);
    if (log_q.size() >= 1) check_eq("add_rsp", log_q[0], rsp_t'({1'b0, 4'h8, 1'b0, 1'b1, 1'b0}));

    // Contention straight out of reset: requester 0 first.
    log_q.delete();
    q0.push_back(cmd_t'({4'hF, 4'h0, 3'b011}));
    q1.push_back(cmd_t'({4'h3, 4'h3, 3'b111}));
    drive();
    do_reset();
    wait_idle("contend", 30);
    check_eq("contend_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check_eq("contend_r0", {log_q[0].id, log_q[0].out, log_q[0].z}, {1'b0, 4'h0, 1'b1});
      check_eq("contend_r1", {log_q[1].id, log_q[1].out, log_q[1].z}, {1'b1, 4'h1, 1'b0});
    end

    // Six back-to-back contended operations alternate.
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(cmd_t'($urandom));
      q1.push_back(cmd_t'($urandom));
    end
    drive();
    wait_idle("alternate", 60);
    check_eq("alternate_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      check_eq("alternate_id", log_q[i].id, i % 2);

    // Response held 5 cycles with req1 pending.
    log_q.delete();
    rdy_fix = 1'b0;
    q0.push_back(cmd_t'($urandom));
    q1.push_back(cmd_t'($urandom));
    drive();
    n = 0;
    while (!(m_busy && cyc > acc_cyc) && n < 20) begin step(); n++; end
    if (n >= 20) check_eq("hold_timeout", 1, 0);
    repeat (5) step();
    rdy_fix = 1'b1;
    drive();
    wait_idle("hold", 30);
    check_eq("hold_count", log_q.size(), 2);
    if (log_q.size() >= 2) check_eq("hold_ids", {log_q[0].id, log_q[1].id}, 2'b01);

    // Reset pulsed during EXEC of a req1 subtract.
    log_q.delete();
    q1.push_back(cmd_t'({4'h2, 4'h5, 3'b001}));
    drive();
    n = 0;
    while (!m_busy && n < 20) begin step(); n++; end
    if (n >= 20) check_eq("exec_reset_timeout", 1, 0);
    do_reset();
    repeat (6) step();
    check_eq("exec_reset_no_rsp", log_q.size(), 0);
    q0.push_back(cmd_t'($urandom));
    q1.push_back(cmd_t'($urandom));
    drive();
    wait_idle("post_reset", 30);
    check_eq("post_reset_count", log_q.size(), 2);
    if (log_q.size() >= 1) check_eq("post_reset_first", log_q[0].id, 0);

    // Randomized traffic and backpressure.
    log_q.delete();
    rand_stim = 1'b1;
    rdy_rand = 1'b1;
    n_rand_left = 150;
    drive();
    wait_idle("random", 5000);
    check_eq("random_count", log_q.size(), 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
